// File: rtl/div_32by16_seq.sv
// rtl/div_32by16_seq.sv - sequential unsigned 32/16 restoring divider, one quotient bit per clock
// Operands on a valid/ready input handshake, quotient/remainder on a valid/ready output handshake.
`timescale 1ns/1ps
module div_32by16_seq #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // The dividend register doubles as the quotient register: each step shifts
  // a dividend bit out of the top and the new quotient bit into the bottom.
  logic [DVD_W-1:0]   r_dvd_sh;
  logic [DVS_W-1:0]   r_dvs;
  logic [DVS_W:0]     r_prem;
  logic [CNT_W-1:0]   r_cnt;
  logic [DVD_W-1:0]   r_quot;
  logic [DVS_W-1:0]   r_rem;
  logic               r_dbz;

  logic               w_dvs_zero;
  logic               w_last;
  logic [DVS_W+1:0]   w_shifted;
  logic [DVS_W+1:0]   w_sub;
  logic               w_borrow;
  logic [DVS_W:0]     w_prem_nxt;
  logic [DVD_W-1:0]   w_dvd_nxt;

  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(DVD_W - 1));

  // Two spare top bits so the sign of the trial subtraction is a plain borrow bit.
  assign w_shifted  = {r_prem, r_dvd_sh[DVD_W-1]};
  assign w_sub      = w_shifted - {2'b00, r_dvs};
  assign w_borrow   = w_sub[DVS_W+1];
  assign w_prem_nxt = w_borrow ? w_shifted[DVS_W:0] : w_sub[DVS_W:0];
  assign w_dvd_nxt  = {r_dvd_sh[DVD_W-2:0], ~w_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd_sh <= '0;
      r_dvs    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_dvs_zero) begin
              r_quot <= '1;
              r_rem  <= dividend[DVS_W-1:0];
              r_dbz  <= 1'b1;
            end else begin
              r_dvd_sh <= dividend;
              r_dvs    <= divisor;
              r_prem   <= '0;
              r_cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          r_dvd_sh <= w_dvd_nxt;
          r_prem   <= w_prem_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_quot <= w_dvd_nxt;
            r_rem  <= w_prem_nxt[DVS_W-1:0];
            r_dbz  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result pins hold the last completed result until the next load.
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/div_32by16_seq.md
Name: div_32by16_seq

Overview:
- Sequential unsigned divider for the arithmetic datapath; it is the inverse of the LUT/carry-chain 16x16 multiplier product path.
- Divides a 32-bit dividend by a 16-bit divisor using radix-2 restoring division, one quotient bit per clock.
- Operands arrive on a valid/ready input handshake; quotient and remainder leave on a valid/ready output handshake.
- Downstream consumers include the detector's scaling and normalisation stages.

Parameters:
- DVD_W, 32, dividend and quotient width.
- DVS_W, 16, divisor and remainder width. Constraint: DVS_W <= DVD_W.
- CNT_W, 6, iteration counter width. Must hold the value DVD_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle and able to accept operands.
- dividend  input  DVD_W  unsigned dividend.
- divisor  input  DVS_W  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DVD_W  unsigned quotient.
- remainder  output  DVS_W  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.
- busy  output  1  high in CALC.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, rst_n clears all state immediately, independent of clk.
- Reset values: state=IDLE, in_ready=1 (decoded from IDLE), out_valid=0, busy=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal operand registers=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid=1, the operands are accepted at that edge.
    - If divisor!=0: latch dividend into the shift register, latch divisor, clear the (DVS_W+1)-bit partial remainder, counter=0, go to CALC.
    - If divisor==0: load quotient={DVD_W{1}}, remainder=dividend[DVS_W-1:0], div_by_zero=1, go directly to DONE. out_valid is high the cycle after acceptance.
  - CALC: busy=1, in_ready=0. Each edge:
    - trial = {partial_rem[DVS_W-1:0], msb of dividend shift register} - {1'b0, divisor}.
    - If trial is non-negative (borrow=0): partial_rem=trial and shift quotient bit 1 in.
    - Otherwise: partial_rem=shifted value and shift quotient bit 0 in.
    - The dividend shift register shifts left by 1.
    - counter increments. The edge where counter==DVD_W-1 completes the last bit: register quotient and remainder, set div_by_zero=0, go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready=1, go to IDLE with out_valid=0. Results remain on the quotient/remainder pins until the next load.
- Latency: operands accepted at edge N; out_valid is high after edge N+DVD_W (32 edges). Divide-by-zero latency is 1 edge.
- Throughput: one division per DVD_W+2 cycles when out_ready is held high. No new acceptance in the same cycle as the result handoff; in_ready rises the cycle after.
- Backpressure: out_valid stays high and quotient/remainder/div_by_zero are unchanged while out_ready=0, indefinitely.
- in_valid while in_ready=0 is ignored. The source must hold its operands until handshake.
- out_ready while out_valid=0 has no effect.
- Width rules:
  - The partial remainder is DVS_W+1 bits to cover the trial carry.
  - The final remainder is always < divisor and fits in DVS_W bits.
  - quotient*divisor+remainder == dividend exactly, for every divisor!=0.
- rst_n asserted mid-CALC or in DONE aborts the operation. All outputs return to reset values immediately and no result is emitted. After deassertion the block is in IDLE with in_ready=1.
- Divisor=1: quotient=dividend, remainder=0.
- Dividend < divisor: quotient=0, remainder=dividend.

Test Plan:
- dividend=100000, divisor=7, out_ready=1 -> quotient=14285, remainder=5, div_by_zero=0, out_valid rises exactly 32 edges after acceptance.
- dividend=32'hFFFF_FFFF, divisor=16'hFFFF -> quotient=32'h0001_0001, remainder=0. A second case with divisor=1 -> quotient=32'hFFFF_FFFF, remainder=0.
- dividend=32'h1234_5678, divisor=0 -> one edge later quotient=32'hFFFF_FFFF, remainder=16'h5678, div_by_zero=1. The next normal division clears div_by_zero.
- dividend=5, divisor=9 with out_ready=0 for 10 cycles after out_valid -> quotient=0, remainder=5 held stable, in_ready=0 throughout. in_valid pulses during that window are ignored. Raising out_ready returns the block to IDLE and in_ready=1 the next cycle.
- Start 100000/7, assert rst_n=0 at CALC counter=15 between clock edges -> out_valid/busy/quotient drop to 0 immediately, with no clock edge. After release, 1000/10 -> quotient=100, remainder=0.
- Random: 10k back-to-back operands with divisor!=0 and random out_ready stalls, checked against a reference model for quotient*divisor+remainder==dividend and remainder<divisor.
